// File: rtl/leglite_ctl_pkg.sv
// Shared types and constants for the LEGLite pipeline control slice.
// Used by pc_hazard_controller and hazard_detect.
package leglite_ctl_pkg;

  localparam int LEG_REG_W    = 5;
  localparam int LEG_ZERO_REG = 31;
  localparam int LEG_CNT_W    = 16;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_REDIRECT   = 2'd2,
    ST_IMEM_WAIT  = 2'd3
  } ctl_state_t;

  // One cycle's worth of pipeline control strobes.
  typedef struct packed {
    logic pc_write;
    logic pc_sel;
    logic ifid_write;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
  } ctl_out_t;

  localparam ctl_out_t CTL_IDLE    = '0;
  localparam ctl_out_t CTL_ADVANCE = '{pc_write: 1'b1, pc_sel: 1'b0, ifid_write: 1'b1,
                                       ifid_flush: 1'b0, idex_flush: 1'b0, exmem_flush: 1'b0};
  localparam ctl_out_t CTL_TAKE    = '{pc_write: 1'b1, pc_sel: 1'b1, ifid_write: 1'b1,
                                       ifid_flush: 1'b1, idex_flush: 1'b1, exmem_flush: 1'b1};
  localparam ctl_out_t CTL_BUBBLE  = '{pc_write: 1'b0, pc_sel: 1'b0, ifid_write: 1'b0,
                                       ifid_flush: 1'b0, idex_flush: 1'b1, exmem_flush: 1'b0};
  localparam ctl_out_t CTL_REFETCH = '{pc_write: 1'b0, pc_sel: 1'b0, ifid_write: 1'b0,
                                       ifid_flush: 1'b1, idex_flush: 1'b0, exmem_flush: 1'b0};

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: flags when the load in EX writes a register the ID
// instruction reads. The zero register never creates a dependency.
module hazard_detect #(
  parameter int REG_W    = 5,
  parameter int ZERO_REG = 31
) (
  input  logic [REG_W-1:0] id_rn_i,
  input  logic [REG_W-1:0] id_rm_i,
  input  logic             id_uses_rm_i,
  input  logic             idex_memread_i,
  input  logic [REG_W-1:0] idex_rd_i,
  output logic             luse_o
);

  logic rd_live;
  logic hit_rn;
  logic hit_rm;

  assign rd_live = idex_memread_i && (idex_rd_i != REG_W'(ZERO_REG));
  assign hit_rn  = (idex_rd_i == id_rn_i);
  assign hit_rm  = id_uses_rm_i && (idex_rd_i == id_rm_i);
  assign luse_o  = rd_live && (hit_rn || hit_rm);

endmodule

// File: rtl/pc_hazard_controller.sv
// LEGLite fetch sequencer: PC/IF-ID advance, hold, redirect and flush control.
// Optional HAZ_PERF_CNT_EN adds saturating stall/flush counters.
module pc_hazard_controller
  import leglite_ctl_pkg::*;
#(
  parameter int REG_W    = LEG_REG_W,
  parameter int ZERO_REG = LEG_ZERO_REG,
  parameter int CNT_W    = LEG_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rn,
  input  logic [REG_W-1:0] id_rm,
  input  logic             id_uses_rm,
  input  logic             idex_memread,
  input  logic [REG_W-1:0] idex_rd,
  input  logic             exmem_branch,
  input  logic             exmem_uncondbranch,
  input  logic             exmem_zero,
  input  logic             imem_ready,
  output logic             pc_write,
  output logic             pc_sel,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
`ifdef HAZ_PERF_CNT_EN
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count,
`endif
  output logic [1:0]       ctl_state
);

  ctl_state_t state_q, state_d;
  ctl_out_t   ctl;
  logic       take;
  logic       luse;

  hazard_detect #(
    .REG_W    (REG_W),
    .ZERO_REG (ZERO_REG)
  ) u_hazard_detect (
    .id_rn_i        (id_rn),
    .id_rm_i        (id_rm),
    .id_uses_rm_i   (id_uses_rm),
    .idex_memread_i (idex_memread),
    .idex_rd_i      (idex_rd),
    .luse_o         (luse)
  );

  assign take = exmem_uncondbranch || (exmem_branch && exmem_zero);

  // take > luse > !imem_ready in every state; REDIRECT ignores luse since ID is a bubble.
  always_comb begin
    state_d = state_q;
    ctl     = CTL_IDLE;
    if (take) begin
      ctl     = CTL_TAKE;
      state_d = ST_REDIRECT;
    end else if (state_q == ST_REDIRECT) begin
      if (!imem_ready) begin
        ctl     = CTL_REFETCH;
        state_d = ST_REDIRECT;
      end else begin
        ctl     = CTL_ADVANCE;
        state_d = ST_RUN;
      end
    end else if (luse) begin
      ctl     = CTL_BUBBLE;
      state_d = ST_LOAD_STALL;
    end else if (!imem_ready) begin
      ctl     = CTL_BUBBLE;
      state_d = ST_IMEM_WAIT;
    end else begin
      ctl     = CTL_ADVANCE;
      state_d = ST_RUN;
    end
    if (!reset) ctl = CTL_IDLE;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  assign pc_write    = ctl.pc_write;
  assign pc_sel      = ctl.pc_sel;
  assign ifid_write  = ctl.ifid_write;
  assign ifid_flush  = ctl.ifid_flush;
  assign idex_flush  = ctl.idex_flush;
  assign exmem_flush = ctl.exmem_flush;
  assign ctl_state   = state_q;

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (!ctl.pc_write && !(&stall_q)) stall_d = stall_q + 1'b1;
    if (take && !(&flush_q))          flush_d = flush_q + 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign stall_count = stall_q;
  assign flush_count = flush_q;
`endif

endmodule

// File: tb/tb_pc_hazard_controller.sv
// Directed-vector bench for pc_hazard_controller; output vector order is
// {pc_write, pc_sel, ifid_write, ifid_flush, idex_flush, exmem_flush}.
module tb_pc_hazard_controller;

  localparam int REG_W = 5;
  localparam int CNT_W = 16;

  logic             clock;
  logic             reset;
  logic [REG_W-1:0] id_rn, id_rm, idex_rd;
  logic             id_uses_rm, idex_memread;
  logic             exmem_branch, exmem_uncondbranch, exmem_zero, imem_ready;
  logic             pc_write, pc_sel, ifid_write, ifid_flush, idex_flush, exmem_flush;
  logic [1:0]       ctl_state;
  logic [5:0]       outs;
`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_count, flush_count;
`endif

  int checks   = 0;
  int failures = 0;

  pc_hazard_controller #(.REG_W(REG_W), .ZERO_REG(31), .CNT_W(CNT_W)) dut (
    .clock              (clock),
    .reset              (reset),
    .id_rn              (id_rn),
    .id_rm              (id_rm),
    .id_uses_rm         (id_uses_rm),
    .idex_memread       (idex_memread),
    .idex_rd            (idex_rd),
    .exmem_branch       (exmem_branch),
    .exmem_uncondbranch (exmem_uncondbranch),
    .exmem_zero         (exmem_zero),
    .imem_ready         (imem_ready),
    .pc_write           (pc_write),
    .pc_sel             (pc_sel),
    .ifid_write         (ifid_write),
    .ifid_flush         (ifid_flush),
    .idex_flush         (idex_flush),
    .exmem_flush        (exmem_flush),
`ifdef HAZ_PERF_CNT_EN
    .stall_count        (stall_count),
    .flush_count        (flush_count),
`endif
    .ctl_state          (ctl_state)
  );

  assign outs = {pc_write, pc_sel, ifid_write, ifid_flush, idex_flush, exmem_flush};

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Inputs change at posedge+1; outputs are read one unit later.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic quiet();
    id_rn = '0; id_rm = '0; idex_rd = '0;
    id_uses_rm = 1'b0; idex_memread = 1'b0;
    exmem_branch = 1'b0; exmem_uncondbranch = 1'b0; exmem_zero = 1'b0;
    imem_ready = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    quiet();
    #1;
    checks++; if (outs !== 6'b000000) begin failures++; $display("FAIL reset_outs got=%b exp=%b", outs, 6'b000000); end
    checks++; if (ctl_state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", ctl_state); end
    reset = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (outs !== 6'b101000) begin failures++; $display("FAIL run_outs[%0d] got=%b exp=%b", i, outs, 6'b101000); end
      checks++; if (ctl_state !== 2'd0) begin failures++; $display("FAIL run_state[%0d] got=%0d exp=0", i, ctl_state); end
      step();
    end
  endtask

  task automatic test_load_use();
    idex_memread = 1'b1; idex_rd = 5'd3; id_rn = 5'd3;
    #1;
    checks++; if (outs !== 6'b000010) begin failures++; $display("FAIL luse_outs got=%b exp=%b", outs, 6'b000010); end
    step();
    quiet();
    #1;
    checks++; if (ctl_state !== 2'd1) begin failures++; $display("FAIL luse_state got=%0d exp=1", ctl_state); end
    checks++; if (outs !== 6'b101000) begin failures++; $display("FAIL luse_exit_outs got=%b exp=%b", outs, 6'b101000); end
    step();
    checks++; if (ctl_state !== 2'd0) begin failures++; $display("FAIL luse_back_run got=%0d exp=0", ctl_state); end
    // rm dependency only counts when the instruction reads rm
    idex_memread = 1'b1; idex_rd = 5'd7; id_rn = 5'd2; id_rm = 5'd7; id_uses_rm = 1'b1;
    #1;
    checks++; if (outs !== 6'b000010) begin failures++; $display("FAIL luse_rm got=%b exp=%b", outs, 6'b000010); end
    id_uses_rm = 1'b0;
    #1;
    checks++; if (outs !== 6'b101000) begin failures++; $display("FAIL luse_rm_unused got=%b exp=%b", outs, 6'b101000); end
    idex_memread = 1'b0; id_uses_rm = 1'b1;
    #1;
    checks++; if (outs !== 6'b101000) begin failures++; $display("FAIL luse_no_load got=%b exp=%b", outs, 6'b101000); end
    quiet();
  endtask

  task automatic test_zero_reg();
    idex_memread = 1'b1; idex_rd = 5'd31; id_rn = 5'd31;
    #1;
    checks++; if (outs !== 6'b101000) begin failures++; $display("FAIL xzr_outs got=%b exp=%b", outs, 6'b101000); end
    step();
    checks++; if (ctl_state !== 2'd0) begin failures++; $display("FAIL xzr_state got=%0d exp=0", ctl_state); end
    quiet();
  endtask

  task automatic test_take_over_luse();
    idex_memread = 1'b1; idex_rd = 5'd4; id_rn = 5'd4;
    exmem_branch = 1'b1; exmem_zero = 1'b1;
    #1;
    checks++; if (outs !== 6'b111111) begin failures++; $display("FAIL take_luse_outs got=%b exp=%b", outs, 6'b111111); end
    step();
    quiet();
    imem_ready = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++; if (ctl_state !== 2'd2) begin failures++; $display("FAIL redir_state[%0d] got=%0d exp=2", i, ctl_state); end
      checks++; if ({pc_write, ifid_flush} !== 2'b01) begin failures++; $display("FAIL redir_wait[%0d] got=%b exp=01", i, {pc_write, ifid_flush}); end
      step();
    end
    // luse is masked while the target fetch completes
    imem_ready = 1'b1; idex_memread = 1'b1; idex_rd = 5'd6; id_rn = 5'd6;
    #1;
    checks++; if (outs !== 6'b101000) begin failures++; $display("FAIL redir_done got=%b exp=%b", outs, 6'b101000); end
    step();
    quiet();
    #1;
    checks++; if (ctl_state !== 2'd0) begin failures++; $display("FAIL redir_to_run got=%0d exp=0", ctl_state); end
  endtask

  task automatic test_branch_variants();
    exmem_branch = 1'b1; exmem_zero = 1'b0;
    #1;
    checks++; if (outs !== 6'b101000) begin failures++; $display("FAIL not_taken got=%b exp=%b", outs, 6'b101000); end
    step();
    checks++; if (ctl_state !== 2'd0) begin failures++; $display("FAIL not_taken_state got=%0d exp=0", ctl_state); end
    quiet();
    exmem_uncondbranch = 1'b1;
    #1;
    checks++; if (outs !== 6'b111111) begin failures++; $display("FAIL uncond got=%b exp=%b", outs, 6'b111111); end
    step();
    quiet();
    #1;
    checks++; if (ctl_state !== 2'd2) begin failures++; $display("FAIL uncond_state got=%0d exp=2", ctl_state); end
    checks++; if (outs !== 6'b101000) begin failures++; $display("FAIL uncond_ready got=%b exp=%b", outs, 6'b101000); end
    step();
  endtask

  task automatic test_back_to_back();
    idex_memread = 1'b1; idex_rd = 5'd9; id_rn = 5'd9;
    #1;
    checks++; if (outs !== 6'b000010) begin failures++; $display("FAIL b2b_first got=%b exp=%b", outs, 6'b000010); end
    step();
    checks++; if ({ctl_state, outs} !== {2'd1, 6'b000010}) begin failures++; $display("FAIL b2b_second got=%b exp=%b", {ctl_state, outs}, {2'd1, 6'b000010}); end
    step();
    quiet();
    #1;
    checks++; if ({ctl_state, outs} !== {2'd1, 6'b101000}) begin failures++; $display("FAIL b2b_exit got=%b exp=%b", {ctl_state, outs}, {2'd1, 6'b101000}); end
    step();
    checks++; if (ctl_state !== 2'd0) begin failures++; $display("FAIL b2b_run got=%0d exp=0", ctl_state); end
  endtask

  task automatic test_imem_wait();
    imem_ready = 1'b0;
    #1;
    checks++; if (outs !== 6'b000010) begin failures++; $display("FAIL iwait_outs got=%b exp=%b", outs, 6'b000010); end
    step();
    checks++; if ({ctl_state, outs} !== {2'd3, 6'b000010}) begin failures++; $display("FAIL iwait_hold got=%b exp=%b", {ctl_state, outs}, {2'd3, 6'b000010}); end
    exmem_branch = 1'b1; exmem_zero = 1'b1;
    #1;
    checks++; if (outs !== 6'b111111) begin failures++; $display("FAIL iwait_take got=%b exp=%b", outs, 6'b111111); end
    step();
    exmem_branch = 1'b0; exmem_zero = 1'b0;
    #1;
    checks++; if (ctl_state !== 2'd2) begin failures++; $display("FAIL iwait_take_state got=%0d exp=2", ctl_state); end
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    step();
    checks++; if (ctl_state !== 2'd3) begin failures++; $display("FAIL iwait_reenter got=%0d exp=3", ctl_state); end
    // async reset lands between edges
    #2;
    reset = 1'b0;
    #1;
    checks++; if (outs !== 6'b000000) begin failures++; $display("FAIL async_rst_outs got=%b exp=%b", outs, 6'b000000); end
    checks++; if (ctl_state !== 2'd0) begin failures++; $display("FAIL async_rst_state got=%0d exp=0", ctl_state); end
    step();
    quiet();
    reset = 1'b1;
    #1;
    checks++; if (outs !== 6'b101000) begin failures++; $display("FAIL post_rst got=%b exp=%b", outs, 6'b101000); end
    step();
    checks++; if (ctl_state !== 2'd0) begin failures++; $display("FAIL post_rst_state got=%0d exp=0", ctl_state); end
  endtask

`ifdef HAZ_PERF_CNT_EN
  task automatic test_perf_counters();
    reset = 1'b0;
    quiet();
    #1;
    reset = 1'b1;
    exmem_uncondbranch = 1'b1;
    step();
    quiet();
    #1;
    checks++; if (flush_count !== 16'd1) begin failures++; $display("FAIL flush_cnt got=%0d exp=1", flush_count); end
    step();
    imem_ready = 1'b0;
    repeat (3) step();
    checks++; if (stall_count !== 16'd3) begin failures++; $display("FAIL stall_cnt got=%0d exp=3", stall_count); end
    repeat ((1 << CNT_W) + 2) step();
    checks++; if (stall_count !== 16'hFFFF) begin failures++; $display("FAIL stall_sat got=%h exp=ffff", stall_count); end
    quiet();
  endtask
`endif

  initial begin
    test_reset();
    test_load_use();
    test_zero_reg();
    test_take_over_luse();
    test_branch_variants();
    test_back_to_back();
    test_imem_wait();
`ifdef HAZ_PERF_CNT_EN
    test_perf_counters();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
